// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART constants and types for the feather-board serial path.
//   DEF_CLK_FREQ     : nominal system clock in Hz
//   DEF_BAUD         : nominal line rate in bit/s
//   clks_per_bit()   : clk cycles per serial bit (integer division)
//   DEF_CLKS_PER_BIT : clks_per_bit() at the default clock/baud
//   rx_state_t       : receiver FSM states
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DEF_CLK_FREQ = 12_000_000;
  localparam int DEF_BAUD     = 115_200;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  localparam int DEF_CLKS_PER_BIT = clks_per_bit(DEF_CLK_FREQ, DEF_BAUD);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// -----------------------------------------------------------------------------
// uart_sync2
// Two-flop synchroniser for an asynchronous single-bit input.
//   clk     : destination clock
//   nRST    : asynchronous active-low reset
//   d       : asynchronous input
//   q       : synchronised output
// RST_VAL sets the value both flops take in reset (idle-high lines use 1).
// -----------------------------------------------------------------------------
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic nRST,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver. The line is sampled once per bit at the bit midpoint,
// shifted in LSB-first and presented on a one-entry valid/ready register.
//   clk       : system clock
//   nRST      : asynchronous active-low reset
//   rx        : serial input, asynchronous, idle high
//   rx_data   : received byte, stable while rx_valid=1
//   rx_valid  : byte available, held until accepted
//   rx_ready  : consumer accepts on a clk edge with rx_valid & rx_ready
//   frame_err : one-cycle pulse, stop bit sampled low
//   overrun   : one-cycle pulse, byte completed while previous unaccepted
//   busy      : high whenever the FSM is not idle
// CLKS_PER_BIT must be at least 4.
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = DEF_CLK_FREQ,
  parameter int BAUD         = DEF_BAUD,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD)
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

  logic            rx_s;
  rx_state_t       state, state_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [2:0]      bit_idx, bit_idx_next;
  logic [7:0]      shift, shift_next;
  logic [7:0]      rx_data_next;
  logic            rx_valid_next;
  logic            frame_err_next;
  logic            overrun_next;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk  (clk),
    .nRST (nRST),
    .d    (rx),
    .q    (rx_s)
  );

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      bit_idx   <= bit_idx_next;
      shift     <= shift_next;
      rx_data   <= rx_data_next;
      rx_valid  <= rx_valid_next;
      frame_err <= frame_err_next;
      overrun   <= overrun_next;
    end
  end

  always_comb begin
    state_next     = state;
    cnt_next       = cnt + 1'b1;
    bit_idx_next   = bit_idx;
    shift_next     = shift;
    rx_data_next   = rx_data;
    // A pending byte is consumed on handshake; a new load below overrides this.
    rx_valid_next  = rx_valid & ~rx_ready;
    frame_err_next = 1'b0;
    overrun_next   = 1'b0;

    case (state)
      IDLE: begin
        cnt_next = '0;
        if (!rx_s) state_next = START;
      end

      START: begin
        if (cnt == CNT_HALF) begin
          cnt_next = '0;
          if (!rx_s) begin
            state_next   = DATA;
            bit_idx_next = '0;
          end else begin
            // Start bit gone by mid-bit: treat as a glitch.
            state_next = IDLE;
          end
        end
      end

      DATA: begin
        if (cnt == CNT_FULL) begin
          cnt_next     = '0;
          shift_next   = {rx_s, shift[7:1]};
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_next = STOP;
        end
      end

      STOP: begin
        if (cnt == CNT_FULL) begin
          cnt_next = '0;
          if (rx_s) begin
            if (!rx_valid || rx_ready) begin
              rx_data_next  = shift;
              rx_valid_next = 1'b1;
            end else begin
              overrun_next = 1'b1;
            end
            // Leaving at mid-stop-bit lets a back-to-back start bit be caught.
            state_next = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = BREAK;
          end
        end
      end

      BREAK: begin
        // Park here until the line returns high so a held-low line
        // produces only a single frame error.
        cnt_next = '0;
        if (rx_s) state_next = IDLE;
      end

      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx at default parameters. Received bytes are
// checked against a scoreboard queue; frame/overrun pulses are counted by a
// monitor and compared per transaction.
// -----------------------------------------------------------------------------
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB  = DEF_CLKS_PER_BIT;
  localparam int HALF = CPB / 2;
  // Edges from driving the start bit to first seeing rx_valid high:
  // 2 synchroniser edges + IDLE detect edge + HALF + 9 bit periods.
  localparam int LAT  = 3 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       nRST = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx u_dut (
    .clk       (clk),
    .nRST      (nRST),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  int         valid_cnt = 0;
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;
  int         valid_rise_cyc = -1;
  int         ovr_cyc = -1;
  int         start_cyc = 0;
  logic       busy_seen = 1'b0;
  logic       prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard: sample away from the active edge.
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (nRST) begin
      if (rx_valid && !prev_valid) valid_rise_cyc = cyc;
      prev_valid = rx_valid;
      if (busy) busy_seen = 1'b1;
      if (frame_err) ferr_cnt++;
      if (overrun) begin
        ovr_cnt++;
        ovr_cyc = cyc;
      end
      if (rx_valid && rx_ready) begin
        valid_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_extra got=%02h expected=none", rx_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (rx_data !== exp_b) begin
            failures++;
            $display("FAIL scoreboard_data got=%02h expected=%02h", rx_data, exp_b);
          end else begin
            $display("rx byte=%02h accepted at cycle %0d", rx_data, cyc);
          end
        end
      end
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #3000000;
    $display("FAIL watchdog_timeout got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, f0, o0, s22;

    vecs[0] = '{data: 8'h55, stop: 1'b1, exp_valid: 1, exp_ferr: 0};
    vecs[1] = '{data: 8'h00, stop: 1'b1, exp_valid: 1, exp_ferr: 0};
    vecs[2] = '{data: 8'h80, stop: 1'b1, exp_valid: 1, exp_ferr: 0};
    vecs[3] = '{data: 8'h01, stop: 1'b1, exp_valid: 1, exp_ferr: 0};
    vecs[4] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1, exp_ferr: 0};
    vecs[5] = '{data: 8'hAA, stop: 1'b0, exp_valid: 0, exp_ferr: 1};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_rx_valid", int'(rx_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_frame_err", int'(frame_err), 0);
    check("reset_overrun", int'(overrun), 0);
    @(posedge clk); #1;
    nRST = 1'b1;
    idle(2 * CPB);

    // Table-driven single frames with rx_ready=1
    for (int i = 0; i < 6; i++) begin
      v0 = valid_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
      valid_rise_cyc = -1;
      if (vecs[i].stop) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].stop);
      idle(2 * CPB);
      $display("vec %0d data=%02h stop=%0b valids=%0d ferrs=%0d", i, vecs[i].data,
               vecs[i].stop, valid_cnt - v0, ferr_cnt - f0);
      check("vec_valid_count", valid_cnt - v0, vecs[i].exp_valid);
      check("vec_frame_err_count", ferr_cnt - f0, vecs[i].exp_ferr);
      check("vec_overrun_count", ovr_cnt - o0, 0);
      if (vecs[i].exp_valid == 1) check("vec_latency", valid_rise_cyc - start_cyc, LAT);
    end

    // Back-to-back frames with no idle gap
    v0 = valid_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    send_frame(8'hA5, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(2 * CPB);
    $display("back_to_back valids=%0d", valid_cnt - v0);
    check("b2b_valid_count", valid_cnt - v0, 2);
    check("b2b_frame_err", ferr_cnt - f0, 0);
    check("b2b_overrun", ovr_cnt - o0, 0);

    // Glitch rejection
    v0 = valid_cnt; f0 = ferr_cnt;
    busy_seen = 1'b0;
    rx = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    idle(2 * CPB);
    $display("glitch busy_seen=%0b busy=%0b", busy_seen, busy);
    check("glitch_busy_seen", int'(busy_seen), 1);
    check("glitch_busy_after", int'(busy), 0);
    check("glitch_valid_count", valid_cnt - v0, 0);
    check("glitch_frame_err", ferr_cnt - f0, 0);

    // Framing error followed by a 2 ms break
    v0 = valid_cnt; f0 = ferr_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    rx = 1'b0;
    repeat (24000) @(posedge clk);
    #1;
    idle(2 * CPB);
    $display("break frame_errs=%0d valids=%0d", ferr_cnt - f0, valid_cnt - v0);
    check("break_frame_err_count", ferr_cnt - f0, 1);
    check("break_valid_count", valid_cnt - v0, 0);
    check("break_busy_after", int'(busy), 0);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    idle(2 * CPB);
    $display("after_break valids=%0d", valid_cnt - v0);
    check("after_break_valid_count", valid_cnt - v0, 1);
    check("after_break_frame_err", ferr_cnt - f0, 1);

    // Overrun: hold rx_ready low across two frames
    rx_ready = 1'b0;
    v0 = valid_cnt; o0 = ovr_cnt;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    idle(CPB);
    ovr_cyc = -1;
    send_frame(8'h22, 1'b1);
    s22 = start_cyc;
    idle(2 * CPB);
    $display("overrun pulses=%0d rx_data=%02h rx_valid=%0b", ovr_cnt - o0, rx_data, rx_valid);
    check("overrun_count", ovr_cnt - o0, 1);
    check("overrun_timing", ovr_cyc - s22, LAT);
    check("overrun_rx_data_kept", int'(rx_data), 8'h11);
    check("overrun_rx_valid_held", int'(rx_valid), 1);
    check("overrun_no_accept", valid_cnt - v0, 0);
    rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("overrun_accept_count", valid_cnt - v0, 1);
    check("overrun_valid_dropped", int'(rx_valid), 0);
    idle(2 * CPB);
    check("overrun_nothing_further", valid_cnt - v0, 1);

    // Reset during data bit 4 of 0xC3
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(int'(8'hC3 >> i) % 2 == 1);
    rx = 1'b0;
    repeat (HALF) @(posedge clk);
    #1;
    check("pre_reset_busy", int'(busy), 1);
    nRST = 1'b0;
    #1;
    $display("mid_frame_reset rx_data=%02h rx_valid=%0b busy=%0b", rx_data, rx_valid, busy);
    check("mid_reset_rx_data", int'(rx_data), 0);
    check("mid_reset_rx_valid", int'(rx_valid), 0);
    check("mid_reset_busy", int'(busy), 0);
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    nRST = 1'b1;
    idle(2 * CPB);
    v0 = valid_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    idle(2 * CPB);
    check("post_reset_valid_count", valid_cnt - v0, 1);
    check("post_reset_frame_err", ferr_cnt - f0, 0);
    check("post_reset_overrun", ovr_cnt - o0, 0);
    check("post_reset_rx_data", int'(rx_data), 8'h5A);

    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver, the counterpart of the existing uart_tx path on the iCE40 feather board.
- Samples the asynchronous serial input once per bit at the bit midpoint, deserialises LSB-first and presents each byte on a one-entry valid/ready output register.
- Sits between the board RX pin and user logic, in the same clk domain as uart_tx (12 MHz nominal).

Parameters:
- CLK_FREQ, 12_000_000, clk frequency in Hz.
- BAUD, 115200, line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer division, 104 at defaults), clk cycles per bit. Must be >= 4.

Ports:
- clk  in  1  system clock.
- nRST  in  1  asynchronous active-low reset.
- rx  in  1  serial input, asynchronous, idle high.
- rx_data  out  8  received byte, stable while rx_valid=1.
- rx_valid  out  1  byte available; held until accepted.
- rx_ready  in  1  consumer accepts when rx_valid & rx_ready at a clk edge.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte completed while previous one unaccepted; new byte dropped.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset is asynchronous on nRST low. Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, state=IDLE, synchroniser flops=1.
- rx passes through a 2-FF synchroniser (rx_s). All decisions use rx_s.
- One counter cnt is used for bit timing; HALF = CLKS_PER_BIT/2.
- IDLE:
  - On rx_s=0, go to START with cnt=0.
- START:
  - When cnt=HALF-1, sample rx_s.
  - If 0: go to DATA, cnt=0, bit index=0.
  - If 1: glitch; return to IDLE with no outputs.
- DATA:
  - When cnt=CLKS_PER_BIT-1, sample rx_s into shift[7] (right shift, so LSB is first on the line), bit index+1, cnt=0.
  - After the 8th sample, go to STOP.
- STOP:
  - When cnt=CLKS_PER_BIT-1, sample rx_s.
  - If 1 and rx_valid=0, or rx_valid=1 with rx_ready=1 on that same cycle: load rx_data=shift and set rx_valid=1 on the next edge.
  - If 1 and rx_valid=1 with rx_ready=0: pulse overrun, keep old rx_data, drop the new byte.
  - Either way, go to IDLE.
  - If 0: pulse frame_err, no valid, go to BREAK.
- BREAK:
  - Wait for rx_s=1, then go to IDLE. A held-low line (break) yields exactly one frame_err.
- Latency: let t0 be the first cycle with rx_s=0 in IDLE. The stop sample is at t0+HALF+9*CLKS_PER_BIT. rx_valid rises one cycle later.
- The return to IDLE at mid-stop-bit supports back-to-back frames with zero idle time.
- Handshake:
  - rx_valid clears on the edge where rx_valid & rx_ready.
  - Simultaneous accept and new-byte load: the new byte wins and rx_valid stays 1.
  - rx_ready is ignored while rx_valid=0.
- A mid-frame nRST discards the partial byte. After release, the receiver resynchronises on the next falling edge.

Decomposition:
- Package uart_pkg holds:
  - default CLK_FREQ and BAUD constants;
  - the CLKS_PER_BIT computation;
  - the rx state enum (IDLE, START, DATA, STOP, BREAK).
  uart_tx shares the constants.
- Sub-module uart_sync2: 2-FF synchroniser with reset value 1, parameterised reset level.

Test Plan:
- Byte receive: nRST pulse, then 0x55 driven at 115200 with rx_ready=1 → rx_valid for exactly 1 cycle, rx_data=0x55, at t0+52+9*104+1 cycles; frame_err=0.
- Back-to-back: 0xA5 then 0x3C with no idle gap, rx_ready=1 → two valids, data 0xA5 then 0x3C, no error pulses.
- Glitch rejection: rx low for 20 cycles, then high → busy high then low again, no rx_valid, no frame_err.
- Framing error and break:
  - 0xFF with stop bit driven 0 → one frame_err pulse, no rx_valid.
  - Line then held low 2 ms → no further frame_err.
  - After release, 0x12 → received correctly.
- Overrun: rx_ready=0, send 0x11 then 0x22 → rx_data stays 0x11, overrun pulse at the 0x22 stop sample. Raise rx_ready → rx_valid drops, nothing further.
- Reset mid-frame: assert nRST during data bit 4 of 0xC3 → outputs reset immediately. After release, 0x5A → rx_data=0x5A, no error pulses.
